ex_muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer in the execute stage. It accepts one M-extension operation when decode flags it as a multiply/divide op (func7 == 1 on OPCODE_OP). It runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, applies sign correction, and returns a 32-bit result with its destination register index. While an operation is in flight it holds a stall request so the pipeline freezes until the result is ready.

---
 rtl/ex_muldiv_seq.sv | 142 ++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or restoring
// divide on operand magnitudes, with the sign fixed up in a final cycle.
module ex_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic [2:0]  md_func3,
  input  logic [31:0] md_op1,
  input  logic [31:0] md_op2,
  input  logic [4:0]  md_rd,
  input  logic        md_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] md_result,
  output logic [4:0]  md_wr_regindex,
  output logic [1:0]  md_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  // Handshake: md_start is a one-cycle request; it is taken whenever the unit is
  // in IDLE or DONE and md_flush is low. md_busy rises combinationally in the
  // request cycle so decode freezes, and stays high through the FIX cycle.
  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  func3_q;
  logic [4:0]  rd_q;
  logic        a_neg_q, b_neg_q;
  logic [63:0] acc;
  logic [31:0] opb;

  logic        a_signed, b_signed, a_neg, b_neg, is_div, div_zero, can_accept;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_signed   = md_func3[2] ? ~md_func3[0] : (md_func3[1:0] != 2'b11);
    b_signed   = md_func3[2] ? ~md_func3[0] : ~md_func3[1];
    a_neg      = a_signed & md_op1[31];
    b_neg      = b_signed & md_op2[31];
    a_mag      = a_neg ? -md_op1 : md_op1;
    b_mag      = b_neg ? -md_op2 : md_op2;
    is_div     = md_func3[2];
    div_zero   = is_div & (md_op2 == 32'd0);
    can_accept = (state == IDLE) || (state == DONE);
  end

  // Multiply keeps the multiplier in acc[31:0] and grows the product from the top;
  // divide keeps the partial remainder in acc[63:32] and shifts quotient bits into
  // acc[31:0] as dividend bits leave it.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_shift = {acc[63:32], acc[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    div_ge    = ~div_diff[33];
    div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};
  end

  logic [63:0] prod;
  logic [31:0] quot, remv, fix_result;

  always_comb begin
    prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
    quot = (a_neg_q ^ b_neg_q) ? -acc[31:0] : acc[31:0];
    remv = a_neg_q ? -acc[63:32] : acc[63:32];
    case (func3_q)
      3'd0:       fix_result = prod[31:0];
      3'd4, 3'd5: fix_result = quot;
      3'd6, 3'd7: fix_result = remv;
      default:    fix_result = prod[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 5'd0;
      func3_q        <= 3'd0;
      rd_q           <= 5'd0;
      a_neg_q        <= 1'b0;
      b_neg_q        <= 1'b0;
      acc            <= 64'd0;
      opb            <= 32'd0;
      md_done        <= 1'b0;
      md_result      <= 32'd0;
      md_wr_regindex <= 5'd0;
    end else begin
      md_done <= 1'b0;
      if (md_flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (md_start) begin
              func3_q <= md_func3;
              rd_q    <= md_rd;
              a_neg_q <= a_neg;
              b_neg_q <= b_neg;
              cnt     <= 5'd0;
              if (div_zero) begin
                // Quotient all ones, remainder is the untouched dividend.
                md_result      <= md_func3[1] ? md_op1 : 32'hFFFF_FFFF;
                md_wr_regindex <= md_rd;
                md_done        <= 1'b1;
                state          <= DONE;
              end else begin
                acc   <= {32'd0, (is_div ? a_mag : b_mag)};
                opb   <= is_div ? b_mag : a_mag;
                state <= CALC;
              end
            end else begin
              state <= IDLE;
            end
          end
          CALC: begin
            acc <= func3_q[2] ? div_next : mul_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= FIX;
          end
          FIX: begin
            md_result      <= fix_result;
            md_wr_regindex <= rd_q;
            md_done        <= 1'b1;
            state          <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign md_busy  = (md_start & can_accept & ~md_flush) | (state == CALC) | (state == FIX);
  assign md_state = state;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq: directed RV32M corner cases, flush/reset interruption,
// back-to-back starts and randomized ops against a 64-bit arithmetic model.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [2:0]  md_func3;
  logic [31:0] md_op1, md_op2;
  logic [4:0]  md_rd;
  logic        md_flush;
  logic        md_busy, md_done;
  logic [31:0] md_result;
  logic [4:0]  md_wr_regindex;
  logic [1:0]  md_state;

  ex_muldiv_seq dut (
    .clk(clk), .rst(rst), .md_start(md_start), .md_func3(md_func3),
    .md_op1(md_op1), .md_op2(md_op2), .md_rd(md_rd), .md_flush(md_flush),
    .md_busy(md_busy), .md_done(md_done), .md_result(md_result),
    .md_wr_regindex(md_wr_regindex), .md_state(md_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard
  logic [31:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];
  int          exp_lat_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: plain 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (f)
      3'd0: begin ps = sa * sb; return ps[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * $signed(ub); return ps[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; ps = sa / sb; return ps[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; ps = sa % sb; return ps[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom();
    endcase
  endfunction

  // driver: call at a falling edge; this cycle becomes T
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp);
    md_start = 1'b1;
    md_func3 = f;
    md_op1   = a;
    md_op2   = b;
    md_rd    = rd;
    exp_q.push_back(exp);
    exp_rd_q.push_back(rd);
    exp_lat_q.push_back((f[2] && b == 0) ? 1 : 34);
    #1 check("busy_req", 32'(md_busy), 32'd1);
  endtask

  // returns in the md_done cycle, just after the falling edge
  task automatic wait_done(input string tag);
    int   lat, busy_cnt;
    logic got;
    lat      = exp_lat_q.pop_front();
    busy_cnt = 0;
    got      = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      md_start = 1'b0;
      #1;
      if (md_done) begin
        got = 1'b1;
        check({tag, "_lat"}, 32'(k), 32'(lat));
        check({tag, "_result"}, md_result, exp_q.pop_front());
        check({tag, "_rd"}, 32'(md_wr_regindex), 32'(exp_rd_q.pop_front()));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
        check({tag, "_busy_done"}, 32'(md_busy), 32'd0);
      end else if (md_busy) begin
        busy_cnt++;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
      void'(exp_rd_q.pop_front());
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    @(negedge clk);
    start_op(f, a, b, rd, exp);
    wait_done(tag);
  endtask

  task automatic idle_cycles(input int n, output int dones);
    dones = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      if (md_done) dones++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    int          dones;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;

    rst = 1'b1; md_start = 1'b0; md_flush = 1'b0;
    md_func3 = 3'd0; md_op1 = 32'd0; md_op2 = 32'd0; md_rd = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_result", md_result, 32'd0);
    check("rst_rd", 32'(md_wr_regindex), 32'd0);
    check("rst_done", 32'(md_done), 32'd0);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_state", 32'(md_state), 32'd0);

    // directed arithmetic corners
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    @(negedge clk);
    #1;
    check("done_pulse", 32'(md_done), 32'd0);
    check("result_hold", md_result, 32'hFFFF_FFEB);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0);
    run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd12, 32'd14);
    run_op("divu_z", 3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
    run_op("remu_z", 3'd7, 32'd5, 32'd0, 5'd14, 32'd5);

    // back-to-back: start again in the DONE cycle
    run_op("b2b_a", 3'd0, 32'd9, 32'd9, 5'd15, 32'd81);
    start_op(3'd5, 32'd1000, 32'd10, 5'd16, 32'd100);
    wait_done("b2b_b");

    // flush at T+10 of a DIV, then start+flush together, then MUL at T+12
    saved = md_result;
    @(negedge clk);
    md_start = 1'b1; md_func3 = 3'd4; md_op1 = 32'd77; md_op2 = 32'd3; md_rd = 5'd17;
    dones = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      md_start = 1'b0;
      #1;
      if (md_done) dones++;
    end
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    #1;
    check("flush_state", 32'(md_state), 32'd0);
    check("flush_busy", 32'(md_busy), 32'd0);
    check("flush_result", md_result, saved);
    md_start = 1'b1; md_flush = 1'b1; md_func3 = 3'd0; md_op1 = 32'd5; md_op2 = 32'd5;
    #1 check("flush_beats_start_busy", 32'(md_busy), 32'd0);
    @(negedge clk);
    md_start = 1'b0; md_flush = 1'b0;
    #1;
    if (md_done) dones++;
    check("flush_start_state", 32'(md_state), 32'd0);
    check("flush_no_done", 32'(dones), 32'd0);
    start_op(3'd0, 32'd3, 32'd4, 5'd18, 32'd12);
    wait_done("after_flush");

    // synchronous reset in the middle of a MUL
    @(negedge clk);
    md_start = 1'b1; md_func3 = 3'd0; md_op1 = 32'd11; md_op2 = 32'd13; md_rd = 5'd19;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      md_start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_result", md_result, 32'd0);
    check("midrst_rd", 32'(md_wr_regindex), 32'd0);
    check("midrst_done", 32'(md_done), 32'd0);
    check("midrst_busy", 32'(md_busy), 32'd0);
    check("midrst_state", 32'(md_state), 32'd0);
    idle_cycles(40, dones);
    check("midrst_no_done", 32'(dones), 32'd0);

    // randomized ops, some chained back-to-back
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = rnd_val();
      b  = rnd_val();
      if (f[2] && $urandom_range(0, 7) == 0) b = 32'd0;
      rd = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      start_op(f, a, b, rd, ref_md(f, a, b));
      wait_done("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
